mem_access_unit: RTL and testbench
==================================

Name: mem_access_unit

Overview:
- MEM-stage access controller of the static pipeline CPU; sits directly upstream of the data memory and drives its word address, write data and write enable.
- Converts byte-addressed MIPS load/store requests (LB/LBU/LH/LHU/LW/SB/SH/SW) into word accesses on the 2048x32 data memory.
- Performs two-cycle read-modify-write for sub-word stores and stalls the pipeline while doing so.
- Registers load results toward the write-back stage.

Parameters:
- BASE_ADDR, 32'h10010000, byte address mapped to data memory word 0.
- MEM_WORDS_LOG2, 11, data memory word-address width; the addressable range is 4<<MEM_WORDS_LOG2 bytes.

Ports:
- clk  in  1  pipeline clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous active-low reset.
- req_valid  in  1  MEM-stage instruction is a load or store.
- req_we  in  1  1=store, 0=load.
- req_size  in  2  00 byte, 01 half, 10 word; 11 is illegal.
- req_unsigned  in  1  zero-extend loads (LBU/LHU); ignored for stores and LW.
- req_addr  in  32  byte address.
- req_wdata  in  32  store data; the low byte or half is used for SB/SH.
- stall  out  1  holds the upstream pipeline registers this cycle.
- rdata  out  32  registered, extended load result.
- rdata_valid  out  1  rdata was updated at the last edge.
- addr_err  out  1  registered one-cycle pulse for a misaligned, out-of-range or illegal-size request.
- dmem_addr  out  MEM_WORDS_LOG2  word address to data memory.
- dmem_wdata  out  32  write data to data memory.
- dmem_we  out  1  write enable to data memory; the memory commits on the falling edge.
- dmem_rdata  in  32  combinational read data from data memory.

Behaviour:
- Byte order is little-endian; the byte lane is req_addr[1:0].
- off = req_addr - BASE_ADDR (32-bit modular).
- Word index = off[MEM_WORDS_LOG2+1:2].
- A request is in range iff off < 4<<MEM_WORDS_LOG2.
- A request is an error if it is out of range, req_size=11, a half access has off[0]=1, or a word access has off[1:0]!=0.

State machine, states IDLE and RMW_WRITE:
- IDLE, no req_valid:
  - dmem_addr = word index of req_addr, dmem_we=0, stall=0.
  - rdata holds; rdata_valid<=0; addr_err<=0.
- IDLE, error request:
  - dmem_we=0, stall=0.
  - addr_err<=1 for one cycle; rdata holds; rdata_valid<=0; state stays IDLE.
- IDLE, load:
  - dmem_addr=index, dmem_we=0, stall=0.
  - At the edge, rdata <= the selected lane, sign- or zero-extended; rdata_valid<=1. Load latency is one edge.
- IDLE, SW:
  - dmem_addr=index, dmem_wdata=req_wdata, dmem_we=1, stall=0.
  - Single cycle; state stays IDLE.
- IDLE, SB/SH, cycle 1:
  - dmem_we=0, stall=1.
  - At the edge, latch merge_word = dmem_rdata with the addressed byte or half replaced by req_wdata[7:0] or [15:0]. Also latch merge_idx=index.
  - Next state is RMW_WRITE.
- RMW_WRITE, cycle 2:
  - dmem_addr=merge_idx, dmem_wdata=merge_word, dmem_we=1, stall=0.
  - Request inputs are ignored; upstream still presents the same held store.
  - Next state is IDLE. Total store latency is 2 cycles with exactly one stall cycle.
- dmem_we, dmem_addr and dmem_wdata are driven from state and registers only in RMW_WRITE, so they are stable across the falling edge.
- rdata_valid and addr_err are 0 in RMW_WRITE and in the cycle after it.

Reset, rst_n=0, asynchronous:
- state=IDLE; rdata=0, rdata_valid=0, addr_err=0, merge_word=0, merge_idx=0.
- Reset asserted in RMW_WRITE drops dmem_we immediately; the pending sub-word store is abandoned and memory is unchanged.

Boundaries:
- Top word (index 2047): legal.
- off = 4<<MEM_WORDS_LOG2: out of range.
- Addresses below BASE_ADDR wrap to a huge off and are out of range.
- Back-to-back sub-word stores each take 2 cycles.
- A load immediately after RMW_WRITE sees the merged word.

Test Plan:
- Reset: hold rst_n=0 mid-RMW_WRITE -> dmem_we=0 at once, rdata=0, rdata_valid=0, state IDLE after release, target word unchanged.
- SW 0xDEADBEEF to 0x10010004, then LW 0x10010004 -> dmem_addr=1, dmem_we=1 for 1 cycle, stall never asserted; next edge rdata=0xDEADBEEF, rdata_valid=1.
- With word 1 = 0xDEADBEEF, SB 0x55 to 0x10010006 -> stall=1 for exactly one cycle, second cycle dmem_wdata=0xDE55BEEF with dmem_we=1. Then LB 0x10010006 gives 0x00000055 and LBU 0x10010007 gives 0x000000DE.
- SH 0x8001 to 0x10010000 on a zero word, then LH and LHU at the same address -> memory 0x00008001; LH gives 0xFFFF8001, LHU gives 0x00008001.
- Misaligned LH at 0x10010003, LW at 0x10010002, and SW at 0x10012000 -> addr_err pulses 1 cycle each, dmem_we never asserted, rdata unchanged.
- Legal LW at 0x10011FFC -> dmem_addr=2047, load returns the stored value.
- Two consecutive SB to the same word at bytes 0 then 3 -> both lanes merged correctly, 4 cycles total, two stall cycles.

Source files
------------

// File: rtl/mem_access_if.sv
// Bundle between the MEM-stage access unit and its two neighbours.
// The pipeline side issues requests and the data memory returns read data.
interface mem_access_if #(
  parameter int MEM_WORDS_LOG2 = 11
);
  logic                      req_valid;
  logic                      req_we;
  logic [1:0]                req_size;
  logic                      req_unsigned;
  logic [31:0]               req_addr;
  logic [31:0]               req_wdata;
  logic                      stall;
  logic [31:0]               rdata;
  logic                      rdata_valid;
  logic                      addr_err;
  logic [MEM_WORDS_LOG2-1:0] dmem_addr;
  logic [31:0]               dmem_wdata;
  logic                      dmem_we;
  logic [31:0]               dmem_rdata;

  // The master is the pipeline plus the data memory around the unit.
  modport master (
    output req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata,
    output dmem_rdata,
    input  stall, rdata, rdata_valid, addr_err,
    input  dmem_addr, dmem_wdata, dmem_we
  );

  modport slave (
    input  req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata,
    input  dmem_rdata,
    output stall, rdata, rdata_valid, addr_err,
    output dmem_addr, dmem_wdata, dmem_we
  );
endinterface

// File: rtl/mem_access_unit.sv
// MEM-stage load/store controller: maps byte-addressed MIPS accesses onto a
// word-wide data memory, using a two-cycle read-modify-write for SB/SH.
module mem_access_unit #(
  parameter logic [31:0] BASE_ADDR      = 32'h10010000,
  parameter int          MEM_WORDS_LOG2 = 11
) (
  input logic         clk,
  input logic         rst_n,
  mem_access_if.slave bus
);

  localparam logic [32:0] RANGE_BYTES = 33'd4 << MEM_WORDS_LOG2;

  localparam logic [1:0] SIZE_BYTE = 2'b00;
  localparam logic [1:0] SIZE_HALF = 2'b01;
  localparam logic [1:0] SIZE_WORD = 2'b10;

  typedef enum logic {IDLE, RMW_WRITE} state_t;

  state_t                    state;
  logic [31:0]               merge_word;
  logic [MEM_WORDS_LOG2-1:0] merge_idx;

  logic [31:0]               off;
  logic                      req_err;
  logic [MEM_WORDS_LOG2-1:0] idx;
  logic [1:0]                lane;
  logic [7:0]                byte_sel;
  logic [15:0]               half_sel;
  logic [31:0]               load_val;
  logic [31:0]               merge_next;

  // Request decode: offset into the memory window and legality.
  always_comb begin
    off     = bus.req_addr - BASE_ADDR;
    lane    = off[1:0];
    idx     = off[MEM_WORDS_LOG2+1:2];
    req_err = ({1'b0, off} >= RANGE_BYTES)
           || (bus.req_size == 2'b11)
           || (bus.req_size == SIZE_HALF && off[0])
           || (bus.req_size == SIZE_WORD && off[1:0] != 2'b00);
  end

  // Lane extraction for loads and lane insertion for sub-word stores.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can
    // leave it unassigned and infer a latch.
    byte_sel   = bus.dmem_rdata[{lane, 3'b000} +: 8];
    half_sel   = bus.dmem_rdata[{lane[1], 4'b0000} +: 16];
    load_val   = bus.dmem_rdata;
    merge_next = bus.dmem_rdata;
    case (bus.req_size)
      SIZE_BYTE: begin
        load_val = bus.req_unsigned ? {24'd0, byte_sel}
                                    : {{24{byte_sel[7]}}, byte_sel};
        merge_next[{lane, 3'b000} +: 8] = bus.req_wdata[7:0];
      end
      SIZE_HALF: begin
        load_val = bus.req_unsigned ? {16'd0, half_sel}
                                    : {{16{half_sel[15]}}, half_sel};
        merge_next[{lane[1], 4'b0000} +: 16] = bus.req_wdata[15:0];
      end
      default: ;
    endcase
  end

  // Memory drive: request-driven in IDLE, register-driven in RMW_WRITE so the
  // write is stable across the falling commit edge.
  always_comb begin
    bus.dmem_addr  = idx;
    bus.dmem_wdata = bus.req_wdata;
    bus.dmem_we    = 1'b0;
    bus.stall      = 1'b0;
    if (state == RMW_WRITE) begin
      bus.dmem_addr  = merge_idx;
      bus.dmem_wdata = merge_word;
      bus.dmem_we    = 1'b1;
    end else if (bus.req_valid && !req_err && bus.req_we) begin
      if (bus.req_size == SIZE_WORD) bus.dmem_we = 1'b1;
      else                           bus.stall   = 1'b1;
    end
  end

  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state           <= IDLE;
      bus.rdata       <= '0;
      bus.rdata_valid <= 1'b0;
      bus.addr_err    <= 1'b0;
      merge_word      <= '0;
      merge_idx       <= '0;
    end else begin
      bus.rdata_valid <= 1'b0;
      bus.addr_err    <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.req_valid) begin
            if (req_err) begin
              bus.addr_err <= 1'b1;
            end else if (!bus.req_we) begin
              bus.rdata       <= load_val;
              bus.rdata_valid <= 1'b1;
            end else if (bus.req_size != SIZE_WORD) begin
              merge_word <= merge_next;
              merge_idx  <= idx;
              state      <= RMW_WRITE;
            end
          end
        end
        RMW_WRITE: state <= IDLE;
        default:   state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed self-checking bench for mem_access_unit with a behavioural
// 2048x32 data memory that commits writes on the falling edge.
module tb_mem_access_unit;

  logic clk;
  logic rst_n;
  int   n_checks = 0;
  int   n_errors = 0;
  int   stalls;

  mem_access_if #(.MEM_WORDS_LOG2(11)) bus ();

  mem_access_unit #(
    .BASE_ADDR     (32'h10010000),
    .MEM_WORDS_LOG2(11)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  logic [31:0] mem [2048];
  logic        mem_ready = 1'b0;

  assign bus.dmem_rdata = mem[bus.dmem_addr];

  always @(negedge clk) begin
    if (!mem_ready) begin
      for (int i = 0; i < 2048; i++) mem[i] <= 32'd0;
      mem_ready <= 1'b1;
    end else if (bus.dmem_we) begin
      mem[bus.dmem_addr] <= bus.dmem_wdata;
    end
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Move to just after the next rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Present a request and let the combinational outputs settle.
  task automatic req(input logic we, input logic [1:0] size, input logic uns,
                     input logic [31:0] addr, input logic [31:0] wdata);
    bus.req_valid    = 1'b1;
    bus.req_we       = we;
    bus.req_size     = size;
    bus.req_unsigned = uns;
    bus.req_addr     = addr;
    bus.req_wdata    = wdata;
    #1;
  endtask

  task automatic idle();
    bus.req_valid = 1'b0;
    #1;
  endtask

  // Issue an illegal request, expect a one-cycle addr_err and no side effects.
  task automatic err_case(input string tag, input logic we, input logic [1:0] size,
                          input logic [31:0] addr, input logic [31:0] keep);
    req(we, size, 1'b0, addr, 32'hBAD0BAD0);
    check({tag, "_we"}, {31'd0, bus.dmem_we}, 32'd0);
    check({tag, "_stall"}, {31'd0, bus.stall}, 32'd0);
    step();
    check({tag, "_err"}, {31'd0, bus.addr_err}, 32'd1);
    check({tag, "_rdata"}, bus.rdata, keep);
    check({tag, "_valid"}, {31'd0, bus.rdata_valid}, 32'd0);
    idle();
    step();
    check({tag, "_err_drop"}, {31'd0, bus.addr_err}, 32'd0);
  endtask

  initial begin
    rst_n            = 1'b0;
    bus.req_valid    = 1'b0;
    bus.req_we       = 1'b0;
    bus.req_size     = 2'b00;
    bus.req_unsigned = 1'b0;
    bus.req_addr     = 32'h10010000;
    bus.req_wdata    = 32'd0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_rdata", bus.rdata, 32'd0);
    check("rst_valid", {31'd0, bus.rdata_valid}, 32'd0);
    check("rst_err", {31'd0, bus.addr_err}, 32'd0);
    check("rst_we", {31'd0, bus.dmem_we}, 32'd0);
    rst_n = 1'b1;
    step();

    // Reset while RMW_WRITE is pending abandons the sub-word store.
    req(1'b1, 2'b10, 1'b0, 32'h10010014, 32'h11223344);
    step();
    req(1'b1, 2'b00, 1'b0, 32'h10010014, 32'h000000AA);
    check("rmwrst_stall", {31'd0, bus.stall}, 32'd1);
    step();
    check("rmwrst_we_pre", {31'd0, bus.dmem_we}, 32'd1);
    rst_n = 1'b0;
    #1;
    check("rmwrst_we_drop", {31'd0, bus.dmem_we}, 32'd0);
    check("rmwrst_rdata", bus.rdata, 32'd0);
    check("rmwrst_valid", {31'd0, bus.rdata_valid}, 32'd0);
    idle();
    step();
    rst_n = 1'b1;
    step();
    check("rmwrst_mem", mem[5], 32'h11223344);
    req(1'b0, 2'b10, 1'b0, 32'h10010014, 32'd0);
    check("rmwrst_idle_stall", {31'd0, bus.stall}, 32'd0);
    step();
    check("rmwrst_load", bus.rdata, 32'h11223344);

    // SW then LW of word 1.
    req(1'b1, 2'b10, 1'b0, 32'h10010004, 32'hDEADBEEF);
    check("sw_addr", {21'd0, bus.dmem_addr}, 32'd1);
    check("sw_we", {31'd0, bus.dmem_we}, 32'd1);
    check("sw_stall", {31'd0, bus.stall}, 32'd0);
    check("sw_wdata", bus.dmem_wdata, 32'hDEADBEEF);
    step();
    req(1'b0, 2'b10, 1'b0, 32'h10010004, 32'd0);
    check("lw_we", {31'd0, bus.dmem_we}, 32'd0);
    check("lw_stall", {31'd0, bus.stall}, 32'd0);
    step();
    check("lw_rdata", bus.rdata, 32'hDEADBEEF);
    check("lw_valid", {31'd0, bus.rdata_valid}, 32'd1);

    // SB into byte 2 of word 1 via read-modify-write.
    req(1'b1, 2'b00, 1'b0, 32'h10010006, 32'h12345655);
    check("sb_stall", {31'd0, bus.stall}, 32'd1);
    check("sb_we_c1", {31'd0, bus.dmem_we}, 32'd0);
    step();
    check("sb_stall_c2", {31'd0, bus.stall}, 32'd0);
    check("sb_we_c2", {31'd0, bus.dmem_we}, 32'd1);
    check("sb_addr_c2", {21'd0, bus.dmem_addr}, 32'd1);
    check("sb_wdata_c2", bus.dmem_wdata, 32'hDE55BEEF);
    check("sb_valid_c2", {31'd0, bus.rdata_valid}, 32'd0);
    step();
    check("sb_valid_after", {31'd0, bus.rdata_valid}, 32'd0);
    check("sb_err_after", {31'd0, bus.addr_err}, 32'd0);
    req(1'b0, 2'b00, 1'b0, 32'h10010006, 32'd0);
    step();
    check("lb_6", bus.rdata, 32'h00000055);
    req(1'b0, 2'b00, 1'b1, 32'h10010007, 32'd0);
    step();
    check("lbu_7", bus.rdata, 32'h000000DE);
    req(1'b0, 2'b00, 1'b0, 32'h10010007, 32'd0);
    step();
    check("lb_7", bus.rdata, 32'hFFFFFFDE);

    // SH into a zero word, then signed and unsigned half loads.
    req(1'b1, 2'b01, 1'b0, 32'h10010000, 32'hFFFF8001);
    check("sh_stall", {31'd0, bus.stall}, 32'd1);
    step();
    check("sh_wdata_c2", bus.dmem_wdata, 32'h00008001);
    step();
    req(1'b0, 2'b01, 1'b0, 32'h10010000, 32'd0);
    step();
    check("lh_0", bus.rdata, 32'hFFFF8001);
    req(1'b0, 2'b01, 1'b1, 32'h10010000, 32'd0);
    step();
    check("lhu_0", bus.rdata, 32'h00008001);
    check("sh_mem", mem[0], 32'h00008001);

    // Illegal requests: misaligned, out of range, below base, bad size.
    err_case("lh_mis", 1'b0, 2'b01, 32'h10010003, 32'h00008001);
    err_case("lw_mis", 1'b0, 2'b10, 32'h10010002, 32'h00008001);
    err_case("sw_oor", 1'b1, 2'b10, 32'h10012000, 32'h00008001);
    err_case("sw_below", 1'b1, 2'b10, 32'h1000FFFC, 32'h00008001);
    err_case("size_11", 1'b0, 2'b11, 32'h10010000, 32'h00008001);
    check("err_mem0", mem[0], 32'h00008001);
    check("err_mem2047", mem[2047], 32'd0);

    // Top legal word.
    req(1'b1, 2'b10, 1'b0, 32'h10011FFC, 32'hCAFEF00D);
    check("top_sw_addr", {21'd0, bus.dmem_addr}, 32'd2047);
    step();
    req(1'b0, 2'b10, 1'b0, 32'h10011FFC, 32'd0);
    check("top_lw_addr", {21'd0, bus.dmem_addr}, 32'd2047);
    step();
    check("top_lw_rdata", bus.rdata, 32'hCAFEF00D);

    // Back-to-back SB to word 3, bytes 0 then 3.
    stalls = 0;
    req(1'b1, 2'b00, 1'b0, 32'h1001000C, 32'h00000011);
    stalls += int'(bus.stall);
    step();
    stalls += int'(bus.stall);
    step();
    req(1'b1, 2'b00, 1'b0, 32'h1001000F, 32'h00000099);
    stalls += int'(bus.stall);
    step();
    stalls += int'(bus.stall);
    check("b2b_we_c4", {31'd0, bus.dmem_we}, 32'd1);
    check("b2b_wdata_c4", bus.dmem_wdata, 32'h99000011);
    step();
    check("b2b_stalls", stalls, 32'd2);
    check("b2b_mem", mem[3], 32'h99000011);
    req(1'b0, 2'b10, 1'b0, 32'h1001000C, 32'd0);
    step();
    check("b2b_lw", bus.rdata, 32'h99000011);
    idle();
    step();

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
